// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: word RAM, byte-lane decode, load extension, misalign flag.
// Latency: WAIT_CYCLES+1 cycles per legal aligned access; rdata is combinational in the completing cycle.
// Backpressure: stall_mem is high for exactly WAIT_CYCLES cycles; the request must be held stable while it is high.
// Optional access counters are enabled with `define DMEM_ACCESS_CNT_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall_mem,
    output logic        addr_err,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    // opcode decode
    logic        is_load;
    logic        is_store;
    logic        sz_byte;
    logic        sz_half;
    logic        sz_word;
    logic        sext;
    logic        misaligned;
    logic        legal;
    logic        req_ok;
    logic        complete;
    logic        stall;

    // RAM access
    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic          we;

    // upper address bits are intentionally ignored so addresses wrap onto the RAM
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // Decode the MIPS opcode into direction, access size and extension mode
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        sext     = 1'b0;
        case (op)
            OP_LB:  begin is_load  = 1'b1; sz_byte = 1'b1; sext = 1'b1; end
            OP_LH:  begin is_load  = 1'b1; sz_half = 1'b1; sext = 1'b1; end
            OP_LW:  begin is_load  = 1'b1; sz_word = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
            OP_SB:  begin is_store = 1'b1; sz_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; sz_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    // Reset gates every request so nothing stalls, flags or writes while rst is low
    assign legal      = is_load | is_store;
    assign misaligned = (sz_half & addr[0]) | (sz_word & (addr[1:0] != 2'b00));
    assign req_ok     = rst & mem_en & legal & ~misaligned;
    assign addr_err   = rst & mem_en & legal & misaligned;

    // State register and wait counter; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: stall for WAIT_CYCLES cycles, then complete without re-triggering
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) begin
                    if (WAIT_N == 4'd0) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!req_ok) begin
                    // request withdrawn by a flush: drop it without touching memory
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt < WAIT_N) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt + 4'd1;
                end else begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign stall_mem = stall;
    assign word_idx  = addr[AW+1:2];
    assign rd_word   = ram[word_idx];

    // Extract the addressed lane (little-endian) and extend it to 32 bits
    always_comb begin
        rd_byte  = 8'h00;
        rd_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (addr[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: ;
        endcase
        if (sz_byte) begin
            load_val = {{24{sext & rd_byte[7]}}, rd_byte};
        end else if (sz_half) begin
            load_val = {{16{sext & rd_half[15]}}, rd_half};
        end
    end

    assign rdata = (complete && is_load) ? load_val : 32'd0;

    // Build byte enables and lane-replicated store data from size and offset
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = wdata;
        if (sz_byte) begin
            byte_en  = 4'b0001 << addr[1:0];
            wr_lanes = {4{wdata[7:0]}};
        end else if (sz_half) begin
            byte_en  = addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{wdata[15:0]}};
        end else if (sz_word) begin
            byte_en  = 4'b1111;
        end
    end

    assign we = complete & is_store;

    // RAM write port: commits on the edge closing the completing cycle; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;

    // Count only accesses that actually complete; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_cnt_q  <= 32'd0;
            store_cnt_q <= 32'd0;
        end else begin
            if (complete && is_load) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (complete && is_store) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
`else
    assign load_cnt  = 32'd0;
    assign store_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with no wait states, one with three.
// Stimulus drivers push expected responses computed from a byte-level memory model.
// Monitors pop and compare whenever an instance completes a request.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int NRAND = 150;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stalls;
    } exp_t;

    logic        clk;
    logic        rst_s [2];
    logic        men   [2];
    logic [5:0]  opv   [2];
    logic [31:0] ad    [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        st    [2];
    logic        ae    [2];
    logic [31:0] lc    [2];
    logic [31:0] sc    [2];

    logic [31:0] mdl [2][DEPTH];
    int          nl [2];
    int          ns [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    int n_chk  = 0;
    int n_pass = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst_s[0]), .mem_en(men[0]), .op(opv[0]), .addr(ad[0]),
        .wdata(wd[0]), .rdata(rd[0]), .stall_mem(st[0]), .addr_err(ae[0]),
        .load_cnt(lc[0]), .store_cnt(sc[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u1 (
        .clk(clk), .rst(rst_s[1]), .mem_en(men[1]), .op(opv[1]), .addr(ad[1]),
        .wdata(wd[1]), .rdata(rd[1]), .stall_mem(st[1]), .addr_err(ae[1]),
        .load_cnt(lc[1]), .store_cnt(sc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    // Reference: size/sign table, word-indexed byte array, wraps modulo DEPTH
    function automatic void model(input int d, input logic [5:0] o, input logic [31:0] a,
                                  input logic [31:0] w, output exp_t e, output logic ok);
        int size = 0;
        bit sx = 0;
        bit isl = 0;
        int idx;
        int off;
        logic [31:0] v;
        e.rd = 32'd0; e.err = 1'b0; e.stalls = 0; ok = 1'b0;
        case (o)
            LB:  begin size = 1; sx = 1; isl = 1; end
            LH:  begin size = 2; sx = 1; isl = 1; end
            LW:  begin size = 4; isl = 1; end
            LBU: begin size = 1; isl = 1; end
            LHU: begin size = 2; isl = 1; end
            SB:  size = 1;
            SH:  size = 2;
            SW:  size = 4;
            default: size = 0;
        endcase
        if (size == 0) return;
        off = int'(a[1:0]);
        idx = int'((a >> 2) % DEPTH);
        if ((off % size) != 0) begin
            e.err = 1'b1;
            return;
        end
        ok = 1'b1;
        e.stalls = (d == 0) ? 0 : 3;
        if (isl) begin
            v = mdl[d][idx] >> (8 * off);
            if (size == 1)      e.rd = sx ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
            else if (size == 2) e.rd = sx ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            else                e.rd = v;
            nl[d]++;
        end else begin
            for (int i = 0; i < size; i++) mdl[d][idx][8*(off+i) +: 8] = w[8*i +: 8];
            ns[d]++;
        end
    endfunction

    // Issue one request, push its expectation, hold it until the DUT stops stalling
    task automatic do_op(input int d, input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
        exp_t e;
        logic ok;
        bit   done = 0;
        model(d, o, a, w, e, ok);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        men[d] = 1'b1; opv[d] = o; ad[d] = a; wd[d] = w;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (!st[d]) done = 1;
        end
        if (!done) chk($sformatf("dut%0d op_timeout", d), 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d, input int n);
        men[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor(input int d);
        int   run = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_s[d]) begin
                run = 0;
            end else if (men[d]) begin
                if (st[d]) begin
                    run++;
                end else begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk($sformatf("dut%0d unexpected_done", d), 32'd1, 32'd0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("dut%0d rdata a=%h op=%h", d, ad[d], opv[d]), rd[d], e.rd);
                        chk($sformatf("dut%0d addr_err a=%h op=%h", d, ad[d], opv[d]), 32'(ae[d]), 32'(e.err));
                        chk($sformatf("dut%0d stall_cycles a=%h op=%h", d, ad[d], opv[d]), 32'(run), 32'(e.stalls));
                    end
                    run = 0;
                end
            end else begin
                chk($sformatf("dut%0d idle_rdata", d), rd[d], 32'd0);
                chk($sformatf("dut%0d idle_stall", d), 32'(st[d]), 32'd0);
            end
        end
    endtask

    localparam int ND = 15;
    localparam logic [5:0]  D_OP [ND] = '{SW, LW, SB, LB, LBU, LW, SH, LH, LHU, LH, SW, LW, SW, LW, 6'h3F};
    localparam logic [31:0] D_AD [ND] = '{32'h10, 32'h10, 32'h21, 32'h21, 32'h21, 32'h20, 32'h32, 32'h32,
                                          32'h32, 32'h33, 32'h31, 32'h30, 32'(4*DEPTH), 32'h0, 32'h10};
    localparam logic [31:0] D_WD [ND] = '{32'h8badf00d, 32'h0, 32'h000000F0, 32'h0, 32'h0, 32'h0, 32'h00008001,
                                          32'h0, 32'h0, 32'h0, 32'hdeadbeef, 32'h0, 32'ha5a55a5a, 32'h0, 32'h0};
    localparam logic [5:0]  ILL [5] = '{6'h00, 6'h0F, 6'h22, 6'h2A, 6'h3F};
    localparam logic [5:0]  LEG [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    task automatic run(input int d);
        logic [31:0] a;
        logic [5:0]  o;
        // fill every word so all later loads compare against known data
        for (int i = 0; i < DEPTH; i++) do_op(d, SW, 32'(4*i), $urandom);
        idle(d, 2);
        for (int i = 0; i < ND; i++) do_op(d, D_OP[i], D_AD[i], D_WD[i]);
        idle(d, 1);
        if (d == 1) begin
            do_op(1, SW, 32'h40, 32'h0);
            // store aborted by reset during its second stall cycle
            men[1] = 1'b1; opv[1] = SW; ad[1] = 32'h40; wd[1] = 32'h12345678;
            @(posedge clk); #1;
            chk("dut1 abort_stall_before_reset", 32'(st[1]), 32'd1);
            rst_s[1] = 1'b0;
            #1;
            chk("dut1 abort_stall", 32'(st[1]), 32'd0);
            chk("dut1 abort_addr_err", 32'(ae[1]), 32'd0);
            chk("dut1 abort_rdata", rd[1], 32'd0);
            men[1] = 1'b0;
            @(posedge clk); #1;
            chk("dut1 reset_load_cnt", lc[1], 32'd0);
            chk("dut1 reset_store_cnt", sc[1], 32'd0);
            rst_s[1] = 1'b1;
            nl[1] = 0; ns[1] = 0;
            @(posedge clk); #1;
            do_op(1, LW, 32'h40, 32'h0);
        end
        for (int i = 0; i < NRAND; i++) begin
            o = ($urandom_range(0, 9) == 0) ? ILL[$urandom_range(0, 4)] : LEG[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_op(d, o, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
        end
        idle(d, 2);
`ifdef DMEM_ACCESS_CNT_EN
        chk($sformatf("dut%0d load_cnt", d), lc[d], 32'(nl[d]));
        chk($sformatf("dut%0d store_cnt", d), sc[d], 32'(ns[d]));
`else
        chk($sformatf("dut%0d load_cnt", d), lc[d], 32'd0);
        chk($sformatf("dut%0d store_cnt", d), sc[d], 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b0; men[d] = 1'b1; opv[d] = LW; ad[d] = 32'h0; wd[d] = 32'h0;
            nl[d] = 0; ns[d] = 0;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset_stall", d), 32'(st[d]), 32'd0);
            chk($sformatf("dut%0d reset_addr_err", d), 32'(ae[d]), 32'd0);
            chk($sformatf("dut%0d reset_rdata", d), rd[d], 32'd0);
            chk($sformatf("dut%0d reset_load_cnt", d), lc[d], 32'd0);
            chk($sformatf("dut%0d reset_store_cnt", d), sc[d], 32'd0);
        end
        #9;
        men[0] = 1'b0; men[1] = 1'b0;
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        fork
            monitor(0);
            monitor(1);
        join_none
        @(posedge clk); #1;
        fork
            run(0);
            run(1);
        join
        repeat (2) @(posedge clk);
        chk("dut0 scoreboard_drained", 32'(q0.size()), 32'd0);
        chk("dut1 scoreboard_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
